// File: rtl/mult_pkg.sv
// Shared definitions for the signed add-shift multiplier: operand width and
// the controller state encoding.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/mult_control_if.sv
// Control bundle between the multiplier sequencer (master) and the
// synchronizers / register unit around it (slave).
interface mult_control_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    localparam int CW = $clog2(WIDTH);

    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          Clr_Ld;
    logic          Clr_XA;
    logic          Add;
    logic          Sub;
    logic          Shift;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Iter;

    modport master (
        input  Run, ClearA_LoadB, M,
        output Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter
    );

    modport slave (
        output Run, ClearA_LoadB, M,
        input  Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done, Iter
    );

endinterface

// File: rtl/iter_counter.sv
// Iteration index for the multiplier: synchronous clear has priority over
// increment; the sequencer never increments past the last iteration.
module iter_counter #(
    parameter int CW = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Counter register with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mult_control.sv
// Sequencer for the signed add-shift multiplier: clear X/A, WIDTH add/shift
// iterations (subtract on the last for the sign bit), then hold Done until Run drops.
module mult_control
    import mult_pkg::*;
#(
    parameter  int WIDTH = MULT_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic            Clk,
    input  logic            Reset,
    mult_control_if.master  bus
);

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e        state_r;
    state_e        state_s;
    logic [CW-1:0] iter_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic          last_s;
    logic          clr_ld_s;
    logic          clr_xa_s;
    logic          add_s;
    logic          sub_s;
    logic          shift_s;
    logic          busy_s;
    logic          done_s;

    iter_counter #(.CW(CW)) u_iter (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .count (iter_s)
    );

    assign last_s = (iter_s == LAST_ITER);

    // State register with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and control decode; Add/Sub also follow the live B LSB
    always_comb begin
        state_s   = state_r;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        clr_ld_s  = 1'b0;
        clr_xa_s  = 1'b0;
        add_s     = 1'b0;
        sub_s     = 1'b0;
        shift_s   = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                clr_ld_s = bus.ClearA_LoadB & ~bus.Run;
                if (bus.Run) begin
                    state_s   = CLR;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            CLR: begin
                clr_xa_s = 1'b1;
                busy_s   = 1'b1;
                state_s  = ADD;
            end
            ADD: begin
                busy_s  = 1'b1;
                state_s = SHIFT;
                // The MSB of a two's-complement multiplier carries negative weight
                if (bus.M) begin
                    if (last_s) begin
                        sub_s = 1'b1;
                    end else begin
                        add_s = 1'b1;
                    end
                end else begin
                    add_s = 1'b0;
                    sub_s = 1'b0;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                busy_s  = 1'b1;
                if (last_s) begin
                    state_s = HOLD;
                end else begin
                    cnt_inc_s = 1'b1;
                    state_s   = ADD;
                end
            end
            HOLD: begin
                done_s = 1'b1;
                if (bus.Run) begin
                    state_s = HOLD;
                end else begin
                    state_s   = IDLE;
                    cnt_clr_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    assign bus.Clr_Ld = clr_ld_s;
    assign bus.Clr_XA = clr_xa_s;
    assign bus.Add    = add_s;
    assign bus.Sub    = sub_s;
    assign bus.Shift  = shift_s;
    assign bus.Busy   = busy_s;
    assign bus.Done   = done_s;
    assign bus.Iter   = iter_s;

endmodule

// File: tb/tb_mult_control.sv
// Directed self-checking bench for mult_control with WIDTH=8; models the B
// register shifting so M follows the multiplier bits one per iteration.
module tb_mult_control;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    mult_control_if #(.WIDTH(8)) bus ();

    mult_control #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Output vector order: {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}
    function automatic logic [6:0] obs();
        return {bus.Clr_Ld, bus.Clr_XA, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        bus.M = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", obs(), 7'b0000000);
        end
        n_cmp++;
        if (bus.Iter !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_iter: got %0d want 0", bus.Iter);
        end
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000000) begin
            n_bad++;
            $display("FAIL idle_quiet: got %b want %b", obs(), 7'b0000000);
        end
    endtask

    task automatic test_clear_load();
        bus.ClearA_LoadB = 1'b1;
        bus.Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            n_cmp++;
            if (obs() !== 7'b1000000) begin
                n_bad++;
                $display("FAIL clear_load[%0d]: got %b want %b", i, obs(), 7'b1000000);
            end
        end
        bus.Run = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 7'b0000000) begin
            n_bad++;
            $display("FAIL run_over_clear: got %b want %b", obs(), 7'b0000000);
        end
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0100010) begin
            n_bad++;
            $display("FAIL clear_to_clr: got %b want %b", obs(), 7'b0100010);
        end
        Reset = 1'b0;
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
    endtask

    // Full multiply from IDLE; cycle k is the cycle after edge k-1 with Run seen at edge 0
    task automatic test_multiply(input logic [7:0] b, input int n_add, input int n_sub,
                                 input logic hold_run, input logic cl_busy, input string name);
        int         adds;
        int         subs;
        int         shifts;
        int         it;
        logic [6:0] exp;
        adds = 0;
        subs = 0;
        shifts = 0;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = cl_busy;
        @(posedge Clk);
        #1 bus.M = b[0];
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0100010) begin
            n_bad++;
            $display("FAIL %s_clr: got %b want %b", name, obs(), 7'b0100010);
        end
        for (int k = 2; k <= 17; k++) begin
            @(posedge Clk);
            #1;
            it = (k - 2) / 2;
            bus.M = b[it];
            if (!hold_run) bus.Run = 1'b0;
            @(negedge Clk);
            if ((k % 2) == 0)
                exp = {2'b00, b[it] && (it < 7), b[it] && (it == 7), 3'b010};
            else
                exp = 7'b0000110;
            n_cmp++;
            if (obs() !== exp || bus.Iter !== 3'(it)) begin
                n_bad++;
                $display("FAIL %s_cyc%0d: got %b iter %0d want %b iter %0d",
                         name, k, obs(), bus.Iter, exp, it);
            end
            adds   += int'(bus.Add);
            subs   += int'(bus.Sub);
            shifts += int'(bus.Shift);
        end
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000001 || bus.Iter !== 3'd7) begin
            n_bad++;
            $display("FAIL %s_done18: got %b iter %0d want %b iter 7", name, obs(), bus.Iter, 7'b0000001);
        end
        if (hold_run) begin
            bus.ClearA_LoadB = 1'b1;
            for (int h = 0; h < 2; h++) begin
                @(posedge Clk);
                @(negedge Clk);
                n_cmp++;
                if (obs() !== 7'b0000001) begin
                    n_bad++;
                    $display("FAIL %s_hold%0d: got %b want %b", name, h, obs(), 7'b0000001);
                end
            end
            bus.Run = 1'b0;
        end
        bus.ClearA_LoadB = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000000) begin
            n_bad++;
            $display("FAIL %s_idle: got %b want %b", name, obs(), 7'b0000000);
        end
        n_cmp++;
        if (adds !== n_add || subs !== n_sub || shifts !== 8) begin
            n_bad++;
            $display("FAIL %s_pulses: got add %0d sub %0d shift %0d want add %0d sub %0d shift 8",
                     name, adds, subs, shifts, n_add, n_sub);
        end
    endtask

    task automatic test_reset_mid();
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b0;
        bus.M = 1'b1;
        @(posedge Clk);
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000110 || bus.Iter !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_shift9: got %b iter %0d want %b iter 3", obs(), bus.Iter, 7'b0000110);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (obs() !== 7'b0000000 || bus.Iter !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got %b iter %0d want %b iter 0", obs(), bus.Iter, 7'b0000000);
        end
        test_multiply(8'hFF, 7, 1, 1'b1, 1'b0, "restart");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        bus.M = 1'b0;
        test_reset();
        test_clear_load();
        test_multiply(8'h07, 3, 0, 1'b1, 1'b0, "b07");
        test_multiply(8'h80, 0, 1, 1'b1, 1'b1, "b80");
        test_multiply(8'hFF, 7, 1, 1'b1, 1'b0, "bff");
        test_multiply(8'h05, 2, 0, 1'b0, 1'b1, "run_drop");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Sequencing controller for the team's 8-bit signed add-shift multiplier datapath (X/A/B registers, 9-bit adder/subtractor).
- Clears the accumulator, then runs WIDTH add-then-shift iterations, with a subtract on the final iteration for two's-complement.
- Parks with Done asserted until Run is released.
- Sits between the top-level switch/button synchronizers and the register unit; generates every load, clear, add, sub and shift enable.

Parameters:
- WIDTH, 8, number of multiplier bits, which is the number of add/shift iterations (WIDTH >= 2).
- CW, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset; Reset==0 at a rising edge forces reset state.
- Run  in  1  level start request, already synchronized; also the release for HOLD.
- ClearA_LoadB  in  1  level request to clear X/A and load B from the switches; honoured only in IDLE.
- M  in  1  current LSB of register B from the datapath; sampled combinationally in ADD.
- Clr_Ld  out  1  clear X/A and load B (IDLE only).
- Clr_XA  out  1  clear X and A before a multiply.
- Add  out  1  load A/X with A + S.
- Sub  out  1  load A/X with A - S.
- Shift  out  1  arithmetic right shift of X:A:B by one.
- Busy  out  1  high in CLR, ADD and SHIFT.
- Done  out  1  high in HOLD.
- Iter  out  CW  current iteration index (debug/observability).

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, HOLD. Reset state is IDLE with Iter=0.
- Outputs are combinational from state, except Add/Sub, which also depend on M. Every output is 0 whenever the state is IDLE and the inputs are low.
- IDLE:
  - Clr_Ld = ClearA_LoadB & ~Run.
  - If Run=1, next state is CLR and Iter <= 0.
  - Run has priority over ClearA_LoadB when both are high.
- CLR: Clr_XA=1. Unconditional transition to ADD.
- ADD:
  - If M=1 and Iter<WIDTH-1, Add=1.
  - If M=1 and Iter==WIDTH-1, Sub=1.
  - If M=0, both are 0.
  - Add and Sub are never both 1. Next state is SHIFT.
- SHIFT:
  - Shift=1.
  - If Iter==WIDTH-1, next state is HOLD; otherwise Iter <= Iter+1 and next state is ADD.
  - Iter does not wrap past WIDTH-1.
- HOLD: Done=1. Stays while Run=1. On Run=0, next state is IDLE.
- Timing: Run sampled high at edge 0 gives CLR in cycle 1, ADD/SHIFT in cycles 2..2*WIDTH+1, and HOLD from cycle 2*WIDTH+2 (cycle 18 for WIDTH=8).
- Exactly WIDTH Shift pulses and at most one Sub pulse per multiply.
- Run deasserted while Busy: ignored; the multiply completes, HOLD lasts one cycle, then IDLE.
- ClearA_LoadB while Busy or in HOLD: ignored; Clr_Ld stays 0.
- Reset low in any state: next cycle is IDLE, Iter=0, all outputs 0. Reset has priority over all inputs.
- Run held high through HOLD->IDLE: cannot happen, because HOLD exits only on Run=0. A new multiply requires a fresh 0->1 level seen in IDLE.
- Unused state encodings go to IDLE.

Decomposition:
- Package mult_pkg holds:
  - the state enum typedef (logic [2:0]: IDLE, CLR, ADD, SHIFT, HOLD);
  - the localparam WIDTH default, shared with the register unit and adder.
- One natural sub-module: iter_counter, a CW-bit counter with sync clear and increment enable, driven by mult_control.
- The rest is a single two-process FSM.

Test Plan:
- Reset=0 for 2 cycles with Run=1 and ClearA_LoadB=1 -> state IDLE, all outputs 0, Iter=0.
- IDLE, ClearA_LoadB=1, Run=0 -> Clr_Ld=1 every cycle, Busy=0. Raise Run -> Clr_Ld=0 in that same cycle, and CLR follows.
- Bench models B=0x07 (M stream 1,1,1,0,0,0,0,0) with Run held -> Clr_XA in cycle 1; Add in cycles 2, 4, 6; 8 Shift pulses; Sub never; Done from cycle 18 until Run=0, then IDLE.
- B=0x80 (M stream 0×7 then 1) -> Add never, Sub=1 only in cycle 16 (Iter=7), 8 Shifts, Done at cycle 18.
- B=0xFF -> Add in cycles 2..14 (even cycles, 7 pulses), Sub in cycle 16, never Add&Sub together.
- Reset driven low in cycle 9 (mid-SHIFT) -> IDLE in cycle 10, outputs 0, Iter=0. Reset high with Run=1 -> a new multiply starts cleanly with CLR.
